// File: rtl/dac_stream_out_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_stream_out_pkg
// Description : Shared definitions for the DAC transmit stream: FSM state
//               encodings, tdata channel field layout and midscale helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dac_stream_out_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_prime = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_PRIME = c_st_prime,
        ST_RUN   = c_st_run
    } dac_state_t;

    // tdata layout, also used by the waveform generator
    localparam int c_sample_w = 16;
    localparam int c_ch_a_lsb = 0;
    localparam int c_ch_b_lsb = 16;

    // Code for a zero sample in inverted offset binary: 0 followed by all ones
    function automatic logic [31:0] dac_midscale(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_stream_out_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dac_stream_out_sync_fifo
// Description : Single-clock first-word-fall-through FIFO with level output
//               and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_stream_out_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_pop,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int             c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_depth = (c_aw + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]       r_wr_ptr;
    logic [c_aw-1:0]       r_rd_ptr;
    logic [c_aw:0]         r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap on their own
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dac_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : dac_stream_out
// Description : AXI4-Stream sample-pair sink driving a two-channel DAC through
//               a priming FIFO, programmable rate divider and code converter.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_stream_out
    import dac_stream_out_pkg::*;
#(
    parameter int DAC_DATA_WIDTH = 14,
    parameter int FIFO_DEPTH     = 16,
    parameter int PRIME_LEVEL    = 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          enable,
    input  logic [15:0]                   rate_div,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [31:0]                   s_axis_tdata,
    output logic [DAC_DATA_WIDTH-1:0]     dac_dat_a,
    output logic [DAC_DATA_WIDTH-1:0]     dac_dat_b,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   underflow_cnt,
    output logic                          running
);

    localparam int                        c_lvl_w     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_lvl_w-1:0]        c_prime_lvl = c_lvl_w'(PRIME_LEVEL);
    localparam logic [DAC_DATA_WIDTH-1:0] c_midscale  =
        DAC_DATA_WIDTH'(dac_midscale(DAC_DATA_WIDTH));

    dac_state_t                r_state;
    dac_state_t                w_next_state;
    logic [15:0]               r_div_cnt;
    logic [DAC_DATA_WIDTH-1:0] r_dac_a;
    logic [DAC_DATA_WIDTH-1:0] r_dac_b;
    logic [31:0]               r_underflow_cnt;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_tick;
    logic                      w_underflow;
    logic                      w_flush;
    logic [c_lvl_w-1:0]        w_level;
    logic [31:0]               w_rd_data;
    logic [c_sample_w-1:0]     w_samp_a;
    logic [c_sample_w-1:0]     w_samp_b;
    logic                      w_unused_lsbs;

    // Keep the top DAC_DATA_WIDTH bits, then invert all but the sign bit
    function automatic logic [DAC_DATA_WIDTH-1:0] to_code(input logic [DAC_DATA_WIDTH-1:0] x);
        return {x[DAC_DATA_WIDTH-1], ~x[DAC_DATA_WIDTH-2:0]};
    endfunction

    assign w_flush       = !enable;
    assign s_axis_tready = (r_state != ST_IDLE) && !w_full;
    assign w_push        = s_axis_tvalid && s_axis_tready;
    assign w_tick        = (r_state == ST_RUN) && enable && (r_div_cnt == '0);
    assign w_pop         = w_tick && !w_empty;
    assign w_underflow   = w_tick && w_empty;

    assign w_samp_a      = w_rd_data[c_ch_a_lsb +: c_sample_w];
    assign w_samp_b      = w_rd_data[c_ch_b_lsb +: c_sample_w];
    assign w_unused_lsbs = ^{w_samp_a, w_samp_b};

    dac_stream_out_sync_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (s_axis_tdata),
        .i_pop   (w_pop),
        .o_data  (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = ST_PRIME;
                ST_PRIME: if (w_level >= c_prime_lvl) w_next_state = ST_RUN;
                ST_RUN:   if (w_underflow) w_next_state = ST_PRIME;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Held at zero outside RUN so the first RUN cycle always ticks
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_div_cnt <= '0;
        end else if (r_state != ST_RUN) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= rate_div;
        end else if (r_div_cnt != '0) begin
            r_div_cnt <= r_div_cnt - 16'd1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_dac_a <= c_midscale;
            r_dac_b <= c_midscale;
        end else if (!enable || (r_state == ST_IDLE) || w_underflow) begin
            r_dac_a <= c_midscale;
            r_dac_b <= c_midscale;
        end else if (w_pop) begin
            r_dac_a <= to_code(w_samp_a[c_sample_w-1 -: DAC_DATA_WIDTH]);
            r_dac_b <= to_code(w_samp_b[c_sample_w-1 -: DAC_DATA_WIDTH]);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_underflow_cnt <= '0;
        end else if (w_underflow && (r_underflow_cnt != '1)) begin
            r_underflow_cnt <= r_underflow_cnt + 32'd1;
        end
    end

    assign dac_dat_a     = r_dac_a;
    assign dac_dat_b     = r_dac_b;
    assign fifo_level    = w_level;
    assign underflow_cnt = r_underflow_cnt;
    assign running       = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_dac_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_stream_out
// Description : Self-checking bench for dac_stream_out: conversion table,
//               pacing, underflow, disable, reset and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_stream_out;

    localparam int W     = 14;
    localparam int DEPTH = 16;
    localparam int PRIME = 8;
    localparam int MID   = (1 << (W - 1)) - 1;

    logic          aclk = 1'b0;
    logic          areset;
    logic          enable;
    logic [15:0]   rate_div;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [31:0]   s_axis_tdata;
    logic [W-1:0]  dac_dat_a;
    logic [W-1:0]  dac_dat_b;
    logic [4:0]    fifo_level;
    logic [31:0]   underflow_cnt;
    logic          running;

    always #5 aclk = ~aclk;

    dac_stream_out dut (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
        .rate_div      (rate_div),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .dac_dat_a     (dac_dat_a),
        .dac_dat_b     (dac_dat_b),
        .fifo_level    (fifo_level),
        .underflow_cnt (underflow_cnt),
        .running       (running)
    );

    typedef struct {
        logic [15:0]  a;
        logic [15:0]  b;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
    } vec_t;

    // Reference model: mode 0 stopped, 1 filling, 2 playing
    int          m_mode;
    logic [31:0] m_q[$];
    int          m_dac_a;
    int          m_dac_b;
    logic [31:0] m_ucnt;
    int          m_next_tick;
    int          cyc;
    int          n_checks;
    int          n_pass;

    // Inverted offset binary is just (2^(W-1)-1) minus the truncated signed value
    function automatic int conv(input logic [15:0] s);
        int v;
        v = $signed(s);
        return MID - (v >>> (16 - W));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_q.delete();
        m_dac_a = MID;
        m_dac_b = MID;
        m_ucnt = '0;
        m_next_tick = 0;
    endtask

    task automatic model_advance(input logic en, input logic [15:0] rd, input logic push,
                                 input logic [31:0] dat);
        logic [31:0] s;
        if (!en) begin
            m_q.delete();
            m_mode = 0;
            m_dac_a = MID;
            m_dac_b = MID;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_q.size() >= PRIME) begin
                m_mode = 2;
                m_next_tick = cyc + 1;
            end
            if (push) m_q.push_back(dat);
        end else begin
            if (cyc == m_next_tick) begin
                if (m_q.size() == 0) begin
                    if (m_ucnt != 32'hFFFF_FFFF) m_ucnt = m_ucnt + 1;
                    m_dac_a = MID;
                    m_dac_b = MID;
                    m_mode = 1;
                end else begin
                    s = m_q.pop_front();
                    m_dac_a = conv(s[15:0]);
                    m_dac_b = conv(s[31:16]);
                    m_next_tick = cyc + int'(rd) + 1;
                end
            end
            if (push) m_q.push_back(dat);
        end
    endtask

    // One clock: drive at negedge, compare shortly after, advance model
    task automatic step(input logic en, input logic [15:0] rd, input logic vld,
                        input logic [31:0] dat, output logic accepted);
        logic exp_tready;
        enable = en;
        rate_div = rd;
        s_axis_tvalid = vld;
        s_axis_tdata = dat;
        #1;
        exp_tready = (m_mode != 0) && (m_q.size() < DEPTH);
        check("tready", 64'(s_axis_tready), 64'(exp_tready));
        check("dac_a", 64'(dac_dat_a), 64'(m_dac_a));
        check("dac_b", 64'(dac_dat_b), 64'(m_dac_b));
        check("level", 64'(fifo_level), 64'(m_q.size()));
        check("underflow_cnt", 64'(underflow_cnt), 64'(m_ucnt));
        check("running", 64'(running), 64'(m_mode == 2));
        accepted = vld && exp_tready;
        model_advance(en, rd, accepted, dat);
        @(negedge aclk);
        cyc++;
    endtask

    task automatic push_one(input logic [15:0] rd, input logic [31:0] dat);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) step(1'b1, rd, 1'b1, dat, ok);
        if (!ok) check("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_running(input logic [15:0] rd);
        logic ok;
        for (int i = 0; i < 20 && !running; i++) step(1'b1, rd, 1'b0, 32'd0, ok);
        if (!running) check("run_timeout", 64'(running), 64'd1);
    endtask

    task automatic apply_reset();
        areset = 1'b1;
        enable = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        model_reset();
        check("rst_dac_a", 64'(dac_dat_a), 64'h1FFF);
        check("rst_dac_b", 64'(dac_dat_b), 64'h1FFF);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_underflow_cnt", 64'(underflow_cnt), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_running", 64'(running), 64'd0);
        @(negedge aclk);
        cyc++;
        areset = 1'b0;
    endtask

    vec_t        tbl [8];
    logic        ok;
    logic [15:0] a;
    logic [W-1:0] prev;
    int          idx;
    int          chg[$];
    logic        saw_full;
    int          pct;
    logic [15:0] rd_r;

    initial begin
        n_checks = 0;
        n_pass = 0;
        cyc = 0;
        areset = 1'b1;
        enable = 1'b0;
        rate_div = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        model_reset();

        tbl[0] = '{16'h0000, 16'h0000, 14'h1FFF, 14'h1FFF};
        tbl[1] = '{16'h0004, 16'hFFFC, 14'h1FFE, 14'h2000};
        tbl[2] = '{16'h0008, 16'h7FFC, 14'h1FFD, 14'h0000};
        tbl[3] = '{16'h000C, 16'h8000, 14'h1FFC, 14'h3FFF};
        tbl[4] = '{16'h0010, 16'h0003, 14'h1FFB, 14'h1FFF};
        tbl[5] = '{16'h0014, 16'hFFFF, 14'h1FFA, 14'h2000};
        tbl[6] = '{16'h7FFC, 16'h1234, 14'h0000, 14'h1B72};
        tbl[7] = '{16'h8000, 16'hC000, 14'h3FFF, 14'h2FFF};

        @(negedge aclk);
        apply_reset();

        // Prime with the table, then play one pair per cycle
        step(1'b1, 16'd0, 1'b0, 32'd0, ok);
        for (int i = 0; i < 8; i++) push_one(16'd0, {tbl[i].b, tbl[i].a});
        wait_running(16'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'd0, 1'b0, 32'd0, ok);
            check("tbl_a", 64'(dac_dat_a), 64'(tbl[i].ea));
            check("tbl_b", 64'(dac_dat_b), 64'(tbl[i].eb));
        end

        // FIFO now drained: the next tick underflows
        step(1'b1, 16'd0, 1'b0, 32'd0, ok);
        check("uf_cnt", 64'(underflow_cnt), 64'd1);
        check("uf_dac_a", 64'(dac_dat_a), 64'h1FFF);
        check("uf_running", 64'(running), 64'd0);
        for (int i = 0; i < 8; i++) push_one(16'd0, {16'h0100, 16'(16'h4000 + (i << 2))});
        wait_running(16'd0);
        step(1'b1, 16'd0, 1'b0, 32'd0, ok);
        check("resume_a", 64'(dac_dat_a), 64'h0FFF);
        check("resume_b", 64'(dac_dat_b), 64'h1FBF);

        // Disable with 5 pairs still queued
        for (int i = 0; i < 10 && fifo_level != 5'd5; i++) step(1'b1, 16'd0, 1'b0, 32'd0, ok);
        check("dis_pre_level", 64'(fifo_level), 64'd5);
        step(1'b0, 16'd0, 1'b0, 32'd0, ok);
        check("dis_level", 64'(fifo_level), 64'd0);
        check("dis_tready", 64'(s_axis_tready), 64'd0);
        check("dis_dac_a", 64'(dac_dat_a), 64'h1FFF);
        check("dis_running", 64'(running), 64'd0);

        // Pacing at rate_div=3 with the source always valid
        idx = 1;
        prev = dac_dat_a;
        saw_full = 1'b0;
        for (int j = 0; j < 130; j++) begin
            a = 16'(idx << 2);
            step(1'b1, 16'd3, 1'b1, {~a, a}, ok);
            if (ok) idx++;
            if (dac_dat_a !== prev) chg.push_back(cyc);
            prev = dac_dat_a;
            if (fifo_level == 5'd16) saw_full = 1'b1;
        end
        check("pace_saw_full", 64'(saw_full), 64'd1);
        check("pace_changes", 64'(chg.size() >= 20), 64'd1);
        for (int k = 1; k < chg.size(); k++) check("pace_interval", 64'(chg[k] - chg[k-1]), 64'd4);

        // Reset while full and playing
        apply_reset();

        for (int blk = 0; blk < 15; blk++) begin
            rd_r = 16'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       pct = 30;
                1:       pct = 60;
                default: pct = 95;
            endcase
            for (int k = 0; k < 200; k++) begin
                step($urandom_range(0, 299) != 0, rd_r, $urandom_range(0, 99) < pct, $urandom(), ok);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
